// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF scheduler: FSM state encoding,
// index-width helper and default threshold/refractory values.
package lif_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [7:0] DEF_THRESH = 8'd127;
   localparam int         DEF_REFRAC = 2;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lif_scheduler_if.sv
// Bus bundle for lif_scheduler: current-write handshake, timestep control,
// spike output and a debug view of the FSM state.
interface lif_scheduler_if
   import lif_pkg::*;
#(
   parameter int IDX_W = 2
);
   // cur_valid/cur_ready: a write transfers on any rising edge where both are
   // high; cur_idx/cur_data must be stable while cur_valid is high.
   logic             cur_valid;
   logic             cur_ready;
   logic [IDX_W-1:0] cur_idx;
   logic [7:0]       cur_data;
   logic             tick;
   logic             busy;
   logic             done;
   logic             spike_valid;
   logic [IDX_W-1:0] spike_idx;
   state_t           dbg_state;

   modport master (
      output cur_valid, cur_idx, cur_data, tick,
      input  cur_ready, busy, done, spike_valid, spike_idx, dbg_state
   );

   modport slave (
      input  cur_valid, cur_idx, cur_data, tick,
      output cur_ready, busy, done, spike_valid, spike_idx, dbg_state
   );
endinterface

// File: rtl/lif_update.sv
// Shared combinational membrane update: leak by half, integrate the buffered
// current with 8-bit wrap, and compare against the spike threshold.
module lif_update
   import lif_pkg::*;
(
   input  logic [7:0] cur_buf,
   input  logic [7:0] mem,
   input  logic [7:0] thresh,
   output logic [7:0] next,
   output logic       fire
);

   always_comb begin
      next = cur_buf + (mem >> 1);
      fire = (next >= thresh);
   end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one neuron visited per
// cycle after a tick. Optional refractory period enabled by LIF_REFRACTORY_EN.
module lif_scheduler
   import lif_pkg::*;
#(
   parameter int         N_NEURONS = 4,
   parameter logic [7:0] THRESH    = DEF_THRESH,
   parameter int         REFRAC    = DEF_REFRAC
) (
   input logic             clk,
   input logic             rst_n,
   lif_scheduler_if.slave  bus
);

   localparam int IDX_W = idx_width(N_NEURONS);

   state_t           state;
   state_t           state_nxt;
   logic             live;
   logic [IDX_W-1:0] idx;
   logic [7:0]       mem  [N_NEURONS];
   logic [7:0]       cbuf [N_NEURONS];
   logic             spike_valid;
   logic [IDX_W-1:0] spike_idx;
   logic [7:0]       upd_next;
   logic             upd_fire;
   logic             visit_fire;
   logic             write_en;
   logic             tick_en;
   logic             last;
   logic [8:0]       wr_sum;
   logic [7:0]       wr_sat;

   assign write_en = bus.cur_valid && bus.cur_ready;
   assign tick_en  = live && (state == ST_IDLE) && bus.tick;
   assign last     = (idx == IDX_W'(N_NEURONS - 1));
   assign wr_sum   = {1'b0, cbuf[bus.cur_idx]} + {1'b0, bus.cur_data};
   assign wr_sat   = wr_sum[8] ? 8'hff : wr_sum[7:0];

   lif_update u_update (
      .cur_buf (cbuf[idx]),
      .mem     (mem[idx]),
      .thresh  (THRESH),
      .next    (upd_next),
      .fire    (upd_fire)
   );

`ifdef LIF_REFRACTORY_EN
   logic [7:0] refr [N_NEURONS];
   logic       refr_active;
   assign refr_active = (refr[idx] != 8'd0);
   assign visit_fire  = upd_fire && !refr_active;
`else
   localparam int unused_refrac = REFRAC;
   assign visit_fire = upd_fire;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (tick_en) state_nxt = ST_UPDATE;
         ST_UPDATE: if (last)    state_nxt = ST_DONE;
         ST_DONE:                state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   // live holds cur_ready low until the first edge after reset release.
   always_comb begin
      bus.cur_ready   = live && (state == ST_IDLE);
      bus.busy        = (state != ST_IDLE) || spike_valid;
      bus.done        = (state == ST_DONE);
      bus.spike_valid = spike_valid;
      bus.spike_idx   = spike_idx;
      bus.dbg_state   = state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live        <= 1'b0;
         idx         <= '0;
         spike_valid <= 1'b0;
         spike_idx   <= '0;
         for (int i = 0; i < N_NEURONS; i++) begin
            mem[i]  <= 8'd0;
            cbuf[i] <= 8'd0;
`ifdef LIF_REFRACTORY_EN
            refr[i] <= 8'd0;
`endif
         end
      end else begin
         live        <= 1'b1;
         spike_valid <= 1'b0;
         if (write_en) cbuf[bus.cur_idx] <= wr_sat;
         if (state == ST_IDLE) idx <= '0;
         if (state == ST_UPDATE) begin
            idx         <= idx + 1'b1;
            cbuf[idx]   <= 8'd0;
            spike_valid <= visit_fire;
            if (visit_fire) spike_idx <= idx;
`ifdef LIF_REFRACTORY_EN
            if (refr_active) begin
               mem[idx]  <= 8'd0;
               refr[idx] <= refr[idx] - 8'd1;
            end else if (upd_fire) begin
               mem[idx]  <= 8'd0;
               refr[idx] <= 8'(REFRAC);
            end else begin
               mem[idx]  <= upd_next;
            end
`else
            mem[idx] <= upd_fire ? 8'd0 : upd_next;
`endif
         end
      end
   end

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed and randomized bench for lif_scheduler against a per-timestep
// arithmetic model; refractory checks apply when LIF_REFRACTORY_EN is defined.
module tb_lif_scheduler;
   import lif_pkg::*;

   localparam int N     = 4;
   localparam int IDX_W = idx_width(N);
   localparam int TH    = 127;
   localparam int RF    = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   lif_scheduler_if #(.IDX_W(IDX_W)) bus ();

   lif_scheduler #(
      .N_NEURONS (N),
      .THRESH    (8'(TH)),
      .REFRAC    (RF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   int m_mem [N];
   int m_buf [N];
   int m_ref [N];
   logic [IDX_W-1:0] exp_q[$];
   int               exp_t[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic wait_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_mem[i] = 0;
         m_buf[i] = 0;
         m_ref[i] = 0;
      end
      exp_q.delete();
      exp_t.delete();
   endtask

   task automatic m_write(input int i, input int d);
      m_buf[i] = (m_buf[i] + d > 255) ? 255 : m_buf[i] + d;
   endtask

   // One timestep from the rules: leak/integrate with wrap, fire, reset.
   task automatic model_step();
      int nxt;
      for (int i = 0; i < N; i++) begin
         if (m_ref[i] > 0) begin
            m_mem[i] = 0;
            m_ref[i] = m_ref[i] - 1;
         end else begin
            nxt = (m_buf[i] + m_mem[i] / 2) % 256;
            if (nxt >= TH) begin
               exp_q.push_back(IDX_W'(i));
               exp_t.push_back(i + 2);
               m_mem[i] = 0;
`ifdef LIF_REFRACTORY_EN
               m_ref[i] = RF;
`endif
            end else begin
               m_mem[i] = nxt;
            end
         end
         m_buf[i] = 0;
      end
   endtask

   task automatic check_state(input string tag);
      for (int i = 0; i < N; i++) begin
         chk({tag, "_mem"}, 32'(dut.mem[i]), 32'(m_mem[i]));
         chk({tag, "_buf"}, 32'(dut.cbuf[i]), 32'(m_buf[i]));
      end
   endtask

   task automatic do_write(input int i, input int d);
      bus.cur_valid = 1'b1;
      bus.cur_idx   = IDX_W'(i);
      bus.cur_data  = 8'(d);
      chk("ready_idle", 32'(bus.cur_ready), 1);
      wait_cyc();
      bus.cur_valid = 1'b0;
      m_write(i, d);
   endtask

   // Tick (optionally with a same-cycle write); junk writes/ticks while busy.
   task automatic run_step(input int has_wr, input int wi, input int wd, output int mask);
      logic exp_v;
      mask = 0;
      bus.tick      = 1'b1;
      bus.cur_valid = 1'(has_wr);
      bus.cur_idx   = IDX_W'(wi);
      bus.cur_data  = 8'(wd);
      if (has_wr != 0) m_write(wi, wd);
      wait_cyc();
      bus.tick      = 1'b0;
      bus.cur_valid = 1'b0;
      model_step();
      for (int k = 1; k <= N + 2; k++) begin
         if (k == N + 2) begin
            bus.cur_valid = 1'b0;
            bus.tick      = 1'b0;
         end
         exp_v = (exp_t.size() > 0) && (exp_t[0] == k);
         chk("busy", 32'(bus.busy), 32'(k <= N + 1));
         chk("ready", 32'(bus.cur_ready), 32'(k == N + 2));
         chk("done", 32'(bus.done), 32'(k == N + 1));
         chk("spike_valid", 32'(bus.spike_valid), 32'(exp_v));
         if (exp_v) begin
            chk("spike_idx", 32'(bus.spike_idx), 32'(exp_q[0]));
            mask = mask | (1 << exp_q[0]);
            void'(exp_q.pop_front());
            void'(exp_t.pop_front());
         end
         if (k <= N + 1) begin
            bus.cur_valid = 1'($urandom_range(0, 1));
            bus.tick      = 1'($urandom_range(0, 1));
            bus.cur_idx   = IDX_W'($urandom_range(0, N - 1));
            bus.cur_data  = 8'($urandom_range(1, 255));
            wait_cyc();
         end
      end
      chk("spike_q_empty", 32'(exp_q.size()), 0);
      check_state("step");
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_ready", 32'(bus.cur_ready), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_spike", 32'(bus.spike_valid), 0);
      chk("rst_spike_idx", 32'(bus.spike_idx), 0);
      wait_cyc();
      chk("rst_hold_done", 32'(bus.done), 0);
      wait_cyc();
      rst_n = 1'b1;
      model_reset();
      chk("rel_ready_before_edge", 32'(bus.cur_ready), 0);
      wait_cyc();
      chk("rel_ready_after_edge", 32'(bus.cur_ready), 1);
      check_state("reset");
   endtask

   initial begin
      int mask;
      int nw;
      bus.cur_valid = 1'b0;
      bus.cur_idx   = '0;
      bus.cur_data  = '0;
      bus.tick      = 1'b0;
      rst_n = 1'b1;
      #2;
      apply_reset();

      // Two-step integrate then fire on neuron 0.
      do_write(0, 100);
      run_step(0, 0, 0, mask);
      chk("n0_step1_mem", 32'(dut.mem[0]), 100);
      chk("n0_step1_nospike", 32'(mask & 1), 0);
      do_write(0, 100);
      run_step(0, 0, 0, mask);
      chk("n0_step2_spike", 32'(mask & 1), 1);
      chk("n0_step2_mem", 32'(dut.mem[0]), 0);

      // Saturating buffer on neuron 1.
      do_write(1, 200);
      do_write(1, 100);
      chk("n1_buf_sat", 32'(dut.cbuf[1]), 255);
      run_step(0, 0, 0, mask);
      chk("n1_spike", 32'((mask >> 1) & 1), 1);

      // 8-bit wrap on neuron 2: 200 + 126/2 = 263 -> 7.
      do_write(2, 126);
      run_step(0, 0, 0, mask);
      chk("n2_pre_mem", 32'(dut.mem[2]), 126);
      chk("n2_pre_nospike", 32'((mask >> 2) & 1), 0);
      do_write(2, 200);
      run_step(0, 0, 0, mask);
      chk("n2_wrap_mem", 32'(dut.mem[2]), 7);
      chk("n2_wrap_nospike", 32'((mask >> 2) & 1), 0);

      // Randomized writes, some coincident with the tick.
      for (int s = 0; s < 15; s++) begin
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++) do_write($urandom_range(0, N - 1), $urandom_range(0, 255));
         run_step($urandom_range(0, 1), $urandom_range(0, N - 1), $urandom_range(0, 255), mask);
      end

      // Reset two cycles into a timestep aborts it.
      do_write(0, 255);
      do_write(1, 50);
      bus.tick = 1'b1;
      wait_cyc();
      bus.tick = 1'b0;
      wait_cyc();
      apply_reset();
      for (int k = 0; k < N + 2; k++) begin
         chk("abort_no_done", 32'(bus.done), 0);
         chk("abort_no_spike", 32'(bus.spike_valid), 0);
         wait_cyc();
      end

`ifdef LIF_REFRACTORY_EN
      // Constant drive of neuron 3: fire, two refractory steps, fire, refractory.
      for (int s = 1; s <= 5; s++) begin
         run_step(1, 3, 255, mask);
         chk("refr_n3_spike", 32'((mask >> 3) & 1), 32'((s == 1) || (s == 4)));
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4: number of time-multiplexed neurons (power of two, 2..16).
REQ-002 SHALL have parameter THRESH, default 127: spike threshold, 8-bit unsigned.
REQ-003 SHALL have parameter REFRAC, default 2: refractory timesteps (used only with LIF_REFRACTORY_EN).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port cur_valid  input  1: current-write request.
REQ-007 SHALL have port cur_ready  output  1: write accepted when cur_valid and cur_ready are both high.
REQ-008 SHALL have port cur_idx  input  IDX_W=log2(N_NEURONS): target neuron of the write.
REQ-009 SHALL have port cur_data  input  8: input current, unsigned.
REQ-010 SHALL have port tick  input  1: start-of-timestep strobe.
REQ-011 SHALL have port busy  output  1: timestep in progress.
REQ-012 SHALL have port done  output  1: one-cycle pulse at end of timestep.
REQ-013 SHALL have port spike_valid  output  1: one-cycle pulse per firing neuron.
REQ-014 SHALL have port spike_idx  output  IDX_W: index of the firing neuron; valid only with spike_valid.

Function
REQ-015 SHALL hold per-neuron 8-bit membrane state mem[i] and 8-bit current buffer buf[i].
REQ-016 SHALL drive cur_ready high only in IDLE; an accepted write SHALL set buf[idx] = min(buf[idx] + cur_data, 255), saturating.
REQ-017 SHALL implement FSM IDLE -> UPDATE -> DONE -> IDLE; tick is sampled only in IDLE and ignored elsewhere.
REQ-018 Tick in IDLE at cycle T SHALL enter UPDATE at T+1 and visit neurons 0..N_NEURONS-1 in order, one per cycle, cycles T+1..T+N_NEURONS.
REQ-019 Per visited neuron i: next = (buf[i] + (mem[i] >> 1)) mod 256, 8-bit wrap; buf[i] cleared to 0 in the same cycle.
REQ-020 If next >= THRESH: spike_valid=1, spike_idx=i registered one cycle after the visit, and mem[i] <= 0; otherwise mem[i] <= next.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE; busy=1 in UPDATE and DONE and in the cycle following the last visit while a spike is still being emitted.
REQ-022 A write and a tick in the same IDLE cycle SHALL both be accepted; the write is included in that timestep.
REQ-023 Neurons with buf=0 SHALL still be visited, decaying as mem>>1.

Reset
REQ-024 rst_n low SHALL immediately force FSM=IDLE, all mem and buf=0, cur_ready=0, busy=0, done=0, spike_valid=0, spike_idx=0.
REQ-025 Reset asserted mid-UPDATE SHALL abort the timestep with no further spike or done pulse; cur_ready SHALL rise on the first clock edge after release.

Configuration
REQ-026 With LIF_REFRACTORY_EN defined, each neuron SHALL keep a refractory counter loaded with REFRAC on spike.
REQ-027 Under LIF_REFRACTORY_EN, while the counter is nonzero, a visit SHALL force mem[i] <= 0, clear buf[i], suppress the spike, and decrement the counter.
REQ-028 Without LIF_REFRACTORY_EN, no counters SHALL exist and the REFRAC parameter SHALL be unused.

Structure
REQ-029 SHALL place the FSM state enum, IDX_W derivation function and default THRESH/REFRAC constants in shared package lif_pkg.
REQ-030 SHALL instantiate combinational sub-module lif_update (inputs buf, mem, thresh; outputs next, fire) as the single shared datapath.

Verification
REQ-031 Write n0=100, tick; write n0=100, tick -> step1 no spike, mem[0]=100; step2 spike_idx=0, mem[0]=0.
REQ-032 Writes 200 then 100 to n1, tick -> buf saturates to 255; spike on n1; done pulses at T+N_NEURONS+1.
REQ-033 Preload mem[2]=126 with no spike, write 200, tick -> next=(200+63) mod 256=7; no spike; mem[2]=7.
REQ-034 cur_valid during UPDATE -> cur_ready=0; no buffer change; tick during busy ignored.
REQ-035 Assert rst_n low at T+2 of a timestep -> all outputs 0 immediately; no done; mem=0 after release.
REQ-036 With LIF_REFRACTORY_EN and REFRAC=2, drive n3 with 255 each step -> spikes at steps 1 and 4 only.
